// File: rtl/video_stream_capture.sv
// video_stream_capture
// AXI4-Stream video sink. Tracks raster position from tuser (start of frame)
// and tlast (end of line), flags frame geometry errors while capturing, and on
// an arm request writes one WIN_W x WIN_H window of the next full frame into a
// 24-bit BRAM write port.
//
// Ports:
//   clk, rstn                  single clock, asynchronous active-low reset
//   s_axis_t*                  pixel stream in; tready is never deasserted
//                              once out of reset
//   arm, win_x, win_y          capture request and window origin (sampled in IDLE)
//   bram_we_o/addr_o/data_o    registered BRAM write port, one cycle per pixel
//   busy_o                     capture armed or in progress
//   done_o                     one-cycle pulse when a capture ends or aborts
//   err_o                      sticky: [0] early EOL, [1] late EOL, [2] early SOF
//   frame_cnt_o                completed frame counter, wraps
module video_stream_capture #(
    parameter int DATA_WIDTH    = 32,
    parameter int SCREEN_WIDTH  = 1920,
    parameter int SCREEN_HEIGHT = 1080,
    parameter int WIN_W         = 320,
    parameter int WIN_H         = 240
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  arm,
    input  logic [12:0]           win_x,
    input  logic [12:0]           win_y,
    output logic                  bram_we_o,
    output logic [16:0]           bram_addr_o,
    output logic [23:0]           bram_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2:0]            err_o,
    output logic [15:0]           frame_cnt_o
);

    localparam logic [12:0] X_LAST = 13'(SCREEN_WIDTH - 1);
    localparam logic [12:0] Y_LAST = 13'(SCREEN_HEIGHT - 1);
    localparam logic [13:0] WIN_W14 = 14'(WIN_W);
    localparam logic [13:0] WIN_H14 = 14'(WIN_H);
    localparam logic [16:0] WIN_W17 = 17'(WIN_W);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_CAPTURE} state_t;

    state_t      state_q, state_d;
    logic        tready_q;
    logic [12:0] x_q, x_d, y_q, y_d;
    logic [12:0] wx_q, wx_d, wy_q, wy_d;
    logic [16:0] row_base_q, row_base_d;
    logic        we_q, we_d;
    logic [16:0] addr_q, addr_d;
    logic [23:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  err_q, err_d;
    logic [15:0] fc_q, fc_d;

    // Upper tdata bits carry no pixel information.
    generate
        if (DATA_WIDTH > 24) begin : g_unused
            logic unused_tdata;
            assign unused_tdata = ^s_axis_tdata[DATA_WIDTH-1:24];
        end
    endgenerate

    logic        beat, eol, early_sof, in_cols, in_rows, proc;
    logic [12:0] cur_x, cur_y, col_off;

    always_comb begin
        beat      = s_axis_tvalid & tready_q;
        // tuser forces the current beat to pixel (0,0) regardless of counters.
        cur_x     = s_axis_tuser ? 13'd0 : x_q;
        cur_y     = s_axis_tuser ? 13'd0 : y_q;
        eol       = s_axis_tlast || (cur_x == X_LAST);
        early_sof = s_axis_tuser && ((x_q != 13'd0) || (y_q != 13'd0));
        // 14-bit compares so a window hanging off the screen edge cannot wrap.
        in_cols   = ({1'b0, cur_x} >= {1'b0, wx_q}) && ({1'b0, cur_x} < ({1'b0, wx_q} + WIN_W14));
        in_rows   = ({1'b0, cur_y} >= {1'b0, wy_q}) && ({1'b0, cur_y} < ({1'b0, wy_q} + WIN_H14));
        col_off   = cur_x - wx_q;
        // Beats that belong to the captured frame: the SOF that starts it, and
        // every capture beat except an aborting early SOF.
        proc      = beat && (((state_q == S_WAIT_SOF) && s_axis_tuser) ||
                             ((state_q == S_CAPTURE) && !early_sof));
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        fc_d       = fc_q;
        state_d    = state_q;
        wx_d       = wx_q;
        wy_d       = wy_q;
        row_base_d = row_base_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        // Raster counters run in every state.
        if (beat) begin
            if (eol) begin
                x_d = 13'd0;
                if (cur_y == Y_LAST) begin
                    y_d  = 13'd0;
                    fc_d = fc_q + 16'd1;
                end else begin
                    y_d = cur_y + 13'd1;
                end
            end else begin
                x_d = cur_x + 13'd1;
                y_d = cur_y;
            end
        end

        case (state_q)
            S_IDLE: begin
                row_base_d = 17'd0;
                if (arm) begin
                    wx_d    = win_x;
                    wy_d    = win_y;
                    err_d   = 3'b000;
                    busy_d  = 1'b1;
                    state_d = S_WAIT_SOF;
                end
            end
            default: begin
                if ((state_q == S_CAPTURE) && beat) begin
                    err_d[0] = err_q[0] | (s_axis_tlast && (cur_x != X_LAST));
                    err_d[1] = err_q[1] | (!s_axis_tlast && (cur_x == X_LAST));
                    err_d[2] = err_q[2] | early_sof;
                    if (early_sof) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                if (proc) begin
                    state_d = S_CAPTURE;
                    if (in_cols && in_rows) begin
                        we_d   = 1'b1;
                        addr_d = row_base_q + {4'd0, col_off};
                        data_d = s_axis_tdata[23:0];
                    end
                    // Row base steps one window row per line inside the window,
                    // so it stays 0 until the first window line is reached.
                    if (eol && in_rows)
                        row_base_d = row_base_q + WIN_W17;
                    if (s_axis_tlast && (cur_y == Y_LAST)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            tready_q   <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            wx_q       <= '0;
            wy_q       <= '0;
            row_base_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            fc_q       <= '0;
        end else begin
            state_q    <= state_d;
            tready_q   <= 1'b1;
            x_q        <= x_d;
            y_q        <= y_d;
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            row_base_q <= row_base_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            fc_q       <= fc_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign bram_we_o     = we_q;
    assign bram_addr_o   = addr_q;
    assign bram_data_o   = data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign frame_cnt_o   = fc_q;

endmodule

// File: tb/tb_video_stream_capture.sv
module tb_video_stream_capture;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0, arm = 1'b0;
    logic        tready;
    logic [12:0] win_x = '0, win_y = '0;
    logic        we, busy, done;
    logic [16:0] addr;
    logic [23:0] wdata;
    logic [2:0]  err;
    logic [15:0] fcnt;

    always #5 clk = ~clk;

    video_stream_capture #(
        .DATA_WIDTH(32), .SCREEN_WIDTH(8), .SCREEN_HEIGHT(4), .WIN_W(4), .WIN_H(2)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tuser(tuser), .s_axis_tlast(tlast),
        .arm(arm), .win_x(win_x), .win_y(win_y),
        .bram_we_o(we), .bram_addr_o(addr), .bram_data_o(wdata),
        .busy_o(busy), .done_o(done), .err_o(err), .frame_cnt_o(fcnt)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    logic [16:0] exp_addr[$];
    logic [23:0] exp_data[$];
    int done_cnt = 0, done_cyc = -1, term_cyc = 0, end_cyc = 0;
    bit gaps = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every BRAM write pops one expected (addr,data).
    always @(negedge clk) begin
        if (rstn) begin
            if (we) begin
                if (exp_addr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", addr, wdata);
                end else begin
                    chk("wr_addr", 32'(addr), 32'(exp_addr.pop_front()));
                    chk("wr_data", 32'(wdata), 32'(exp_data.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push(input int a, input int d);
        exp_addr.push_back(17'(a));
        exp_data.push_back(24'(d));
    endtask

    // Window (2,1) of a clean frame: rows y=1,2, columns x=2..5, pixel = y*16+x.
    task automatic push_nominal();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                push(r * 4 + c, (r + 1) * 16 + c + 2);
    endtask

    task automatic beat(input int x, input int y, input logic u, input logic l, input logic a = 1'b0);
        if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
                tvalid = 1'b0;
                @(posedge clk); #1;
            end
        end
        tdata  = {8'hA5, 24'(y * 16 + x)};
        tuser  = u;
        tlast  = l;
        arm    = a;
        tvalid = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; arm = 1'b0;
        term_cyc = cyc;
    endtask

    // Line y with n beats; tlast optionally on the last one.
    task automatic send_line(input int y, input int n, input logic l);
        for (int x = 0; x < n; x++)
            beat(x, y, (x == 0 && y == 0), (l && x == n - 1));
    endtask

    task automatic send_frame();
        for (int y = 0; y < 4; y++) send_line(y, 8, 1'b1);
    endtask

    task automatic do_arm(input int wx, input int wy);
        win_x = 13'(wx);
        win_y = 13'(wy);
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        chk("busy_after_arm", 32'(busy), 32'd1);
        chk("err_cleared_by_arm", 32'(err), 32'd0);
    endtask

    task automatic check_end(input string name, input int done_before, input int exp_err);
        @(posedge clk); #1;
        chk({name, "_done_count"}, 32'(done_cnt), 32'(done_before + 1));
        chk({name, "_done_cycle"}, 32'(done_cyc), 32'(end_cyc));
        chk({name, "_busy_low"}, 32'(busy), 32'd0);
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_writes_left"}, 32'(exp_addr.size()), 32'd0);
    endtask

    int d0;

    initial begin
        // Reset: beats driven while held in reset must not be accepted.
        tvalid = 1'b1; tuser = 1'b1; tlast = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tready", 32'(tready), 32'd0);
        chk("reset_outputs", {12'd0, we, busy, done, err, fcnt}, 32'd0);
        chk("reset_addr_data", {addr[7:0], wdata}, 32'd0);
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("tready_after_release", 32'(tready), 32'd1);
        chk("outputs_after_release", {12'd0, we, busy, done, err, fcnt}, 32'd0);

        // Nominal capture over two clean frames.
        d0 = done_cnt;
        push_nominal();
        do_arm(2, 1);
        send_frame();
        end_cyc = term_cyc;
        send_frame();
        check_end("nominal", d0, 0);
        chk("nominal_frame_cnt", 32'(fcnt), 32'd2);

        // Arm during pixel (3,2): capture starts on the next frame's SOF.
        d0 = done_cnt;
        push_nominal();
        send_line(0, 8, 1'b1);
        send_line(1, 8, 1'b1);
        for (int x = 0; x < 8; x++) beat(x, 2, 1'b0, x == 7, x == 3);
        chk("busy_mid_frame_arm", 32'(busy), 32'd1);
        send_line(3, 8, 1'b1);
        chk("no_write_before_sof", 32'(exp_addr.size()), 32'd8);
        send_frame();
        end_cyc = term_cyc;
        check_end("arm_mid_frame", d0, 0);

        // Window clipped by the bottom-right screen corner.
        d0 = done_cnt;
        push(0, 'h36); push(1, 'h37);
        do_arm(6, 3);
        send_frame();
        end_cyc = term_cyc;
        check_end("clipped", d0, 0);

        // Early EOL on line 1 (tlast at x=5): line realigns to y=2.
        d0 = done_cnt;
        push_nominal();
        do_arm(2, 1);
        send_line(0, 8, 1'b1);
        send_line(1, 6, 1'b1);
        send_line(2, 8, 1'b1);
        send_line(3, 8, 1'b1);
        end_cyc = term_cyc;
        check_end("early_eol", d0, 1);

        // Late EOL: x=7 on line 0 without tlast.
        d0 = done_cnt;
        push_nominal();
        do_arm(2, 1);
        send_line(0, 8, 1'b0);
        for (int y = 1; y < 4; y++) send_line(y, 8, 1'b1);
        end_cyc = term_cyc;
        check_end("late_eol", d0, 2);

        // Early SOF at (4,2): abort, that beat not written.
        d0 = done_cnt;
        for (int c = 0; c < 4; c++) push(c, 'h12 + c);
        push(4, 'h22); push(5, 'h23);
        do_arm(2, 1);
        send_line(0, 8, 1'b1);
        send_line(1, 8, 1'b1);
        for (int x = 0; x < 4; x++) beat(x, 2, 1'b0, 1'b0);
        beat(4, 2, 1'b1, 1'b0);
        end_cyc = term_cyc;
        check_end("early_sof", d0, 4);

        // Re-arm clears errors; nominal capture with random tvalid gaps.
        d0 = done_cnt;
        push_nominal();
        do_arm(2, 1);
        gaps = 1'b1;
        send_frame();
        gaps = 1'b0;
        end_cyc = term_cyc;
        check_end("gaps", d0, 0);
        chk("final_frame_cnt", 32'(fcnt), 32'd8);

        repeat (3) @(posedge clk);
        #1;
        chk("no_stray_done", 32'(done_cnt), 32'(d0 + 1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_stream_capture.md
# video_stream_capture

AXI4-Stream video sink that consumes the pixel stream produced by the video image generator, tracks raster position from tuser (SOF) and tlast (EOL), and checks frame geometry. On an arm request it captures one rectangular window of the next full frame into a 24-bit block RAM through its write port, for readback by software or a checker. It sits at the downstream end of the video pipeline, opposite the BRAM-backed pattern generator.

## Interface
- DATA_WIDTH, 32, tdata width; pixel is tdata[23:0], remaining bits ignored
- SCREEN_WIDTH, 1920, active pixels per line
- SCREEN_HEIGHT, 1080, active lines per frame
- WIN_W, 320, capture window width in pixels
- WIN_H, 240, capture window height in lines; WIN_W*WIN_H ≤ 131072
- clk  in  1  single clock for all logic
- rstn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  DATA_WIDTH  pixel data
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  sink ready
- s_axis_tuser  in  1  start of frame, on pixel (0,0)
- s_axis_tlast  in  1  end of line
- arm  in  1  single-cycle capture request
- win_x  in  13  window left column, sampled on accepted arm
- win_y  in  13  window top line, sampled on accepted arm
- bram_we_o  out  1  BRAM write enable
- bram_addr_o  out  17  BRAM write address
- bram_data_o  out  24  BRAM write data
- busy_o  out  1  capture armed or in progress
- done_o  out  1  one-cycle capture-complete pulse
- err_o  out  3  sticky flags: [0] early EOL, [1] late EOL, [2] early SOF
- frame_cnt_o  out  16  completed frames, wraps at 65535→0

## Operation
- beat = s_axis_tvalid & s_axis_tready. s_axis_tready is a register: 0 in reset, 1 from the first clk edge after rstn deasserts, then constant 1 (no backpressure).
- Position counters x (13b), y (13b) run in every state. Current beat's position is (x,y), or (0,0) if tuser is set.
- After a beat: if tlast or x==SCREEN_WIDTH-1, then x←0; y←y+1, or y←0 with frame_cnt_o+1 when y==SCREEN_HEIGHT-1. Otherwise x←x+1.
- Errors are set only in CAPTURE:
  - err[0]: tlast with x≠SCREEN_WIDTH-1.
  - err[1]: x==SCREEN_WIDTH-1 without tlast.
  - err[2]: tuser with (x,y)≠(0,0).
  - Counters realign in all three cases as above.
- State machine:
  - IDLE: arm → WAIT_SOF. Latch win_x/win_y, clear err_o, busy_o←1.
  - WAIT_SOF: beat with tuser → CAPTURE. That beat is processed as pixel (0,0). Beats without tuser are discarded.
  - CAPTURE: every beat whose position satisfies win_x≤x<win_x+WIN_W and win_y≤y<win_y+WIN_H is written at address (y−win_y)*WIN_W+(x−win_x). Window parts outside the screen are never written.
  - CAPTURE → IDLE on a tlast beat at y==SCREEN_HEIGHT-1 (normal end), or on an early-SOF beat (abort, err[2] set). Either exit pulses done_o and clears busy_o. On abort, the early-SOF beat is not written.
- arm is ignored in WAIT_SOF and CAPTURE.
- Address arithmetic uses no multiplier: row base accumulates +WIN_W per window line.

## Timing
- Reset values: s_axis_tready 0, bram_we_o 0, bram_addr_o 0, bram_data_o 0, busy_o 0, done_o 0, err_o 0, frame_cnt_o 0. State is IDLE and x=y=0.
- BRAM write latency is 1: bram_we_o/addr/data are registered in the cycle after the qualifying beat. bram_we_o is high for exactly one cycle per written pixel.
- busy_o rises the cycle after arm is sampled.
- done_o pulses, and busy_o falls, the cycle after the terminating beat, coincident with the final BRAM write when there is one.
- err_o bits assert the cycle after the offending beat and hold until the next accepted arm.
- frame_cnt_o updates the cycle after the frame-final tlast beat.
- rstn asserted mid-capture: all outputs and state return to reset values immediately. No partial done_o is issued.
- tvalid gaps stall counters only; no timeouts.

## Test plan
Simulate with SCREEN_WIDTH=8, SCREEN_HEIGHT=4, WIN_W=4, WIN_H=2.
- Reset: hold rstn low, drive beats → s_axis_tready=0, no counter motion. Release → tready=1 next cycle, all outputs 0.
- Nominal capture: arm with win=(2,1), send 2 clean frames with pixel value = y*16+x. Required response: 8 writes, addr 0..7, data 0x12,0x13,0x14,0x15,0x22..0x25. done_o once, at end of frame 1. err_o=0, frame_cnt_o=2.
- Arm mid-frame: arm at pixel (3,2) of frame 0 → nothing written until frame 1's tuser, then the same 8 writes.
- Clipped window: win=(6,3) → writes only addr 0,1 (x=6,7 on y=3). done_o at frame end.
- Geometry errors during capture:
  - tlast at x=5 → err_o[0]=1, line realigns.
  - x=7 without tlast → err_o[1]=1.
  - tuser at (4,2) → err_o[2]=1, immediate done_o, busy_o=0.
  - A re-arm clears err_o to 0.
- Random tvalid gaps (≈50% duty) on the nominal case → identical write sequence, done_o one cycle after the last beat.
